// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one ALU among NREQ requesters; define ALU_ARB_FIXED_PRIO_EN for fixed priority instead of round-robin
module alu_arbiter #(
  parameter int N           = 32,
  parameter int NREQ        = 4,
  parameter int IDW         = 2,
  parameter int EXEC_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*N-1:0] req_a,
  input  logic [NREQ*N-1:0] req_b,
  input  logic [NREQ*3-1:0] req_op,
  output logic [N-1:0]      alu_a,
  output logic [N-1:0]      alu_b,
  output logic [2:0]        alu_ctrl,
  input  logic [N-1:0]      alu_result,
  input  logic [3:0]        alu_flags,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [N-1:0]      rsp_result,
  output logic [3:0]        rsp_flags
);
`ifdef ALU_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif
  localparam int CW = EXEC_CYCLES > 1 ? $clog2(EXEC_CYCLES) : 1;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state, state_n;
  logic [IDW-1:0] rr_ptr, id_q, gnt;
  logic [CW-1:0] cnt;
  logic any;
  logic take;
  // pick the first valid requester, scanning from rr_ptr (or from 0 in fixed priority)
  always_comb begin
    any = 1'b0;
    gnt = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_valid[FIXED ? k : (int'(rr_ptr) + k) % NREQ]) begin
        any = 1'b1;
        gnt = IDW'(FIXED ? k : (int'(rr_ptr) + k) % NREQ);
      end
    end
  end
  // next state and combinational grant
  always_comb begin
    take = state == IDLE && any && !rst;
    req_ready = take ? {{(NREQ-1){1'b0}}, 1'b1} << gnt : '0;
    state_n = state == IDLE ? (any ? EXEC : IDLE) :
              state == EXEC ? (cnt == '0 ? RESP : EXEC) :
              (rsp_ready ? IDLE : RESP);
  end
  // state register, operand latch, exec countdown and response capture
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      id_q       <= '0;
      cnt        <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_ctrl   <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_result <= '0;
      rsp_flags  <= '0;
    end else begin
      state <= state_n;
      if (take) begin
        alu_a    <= req_a[gnt*N +: N];
        alu_b    <= req_b[gnt*N +: N];
        alu_ctrl <= req_op[gnt*3 +: 3];
        id_q     <= gnt;
        cnt      <= CW'(EXEC_CYCLES - 1);
        rr_ptr   <= FIXED ? '0 : IDW'((int'(gnt) + 1) % NREQ);
      end
      if (state == EXEC && cnt != '0) cnt <= cnt - 1'b1;
      if (state == EXEC && cnt == '0) begin
        rsp_valid  <= 1'b1;
        rsp_result <= alu_result;
        rsp_flags  <= alu_flags;
        rsp_id     <= id_q;
      end
      if (state == RESP && rsp_ready) rsp_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: vector, directed and randomized checks of alu_arbiter against a transaction-level model
module tb_alu_arbiter;
  localparam int N = 32, NREQ = 4, IDW = 2;
`ifdef ALU_ARB_FIXED_PRIO_EN
  localparam bit FP = 1'b1;
`else
  localparam bit FP = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic [NREQ-1:0] req_valid = '0;
  logic [NREQ*N-1:0] req_a = '0, req_b = '0;
  logic [NREQ*3-1:0] req_op = '0;
  logic rsp_ready = 1'b0;
  logic [NREQ-1:0] u0_req_ready, u3_req_ready;
  logic [N-1:0] u0_alu_a, u0_alu_b, u0_res, u3_alu_a, u3_alu_b, u3_res;
  logic [2:0] u0_alu_ctrl, u3_alu_ctrl;
  logic [3:0] u0_fl, u3_fl, u0_rsp_flags, u3_rsp_flags;
  logic u0_rsp_valid, u3_rsp_valid;
  logic [IDW-1:0] u0_rsp_id, u3_rsp_id;
  logic [N-1:0] u0_rsp_result, u3_rsp_result;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  // behavioural ALU: returns {cout, zero, neg, overflow, result}
  function automatic logic [35:0] alu_fn(logic [31:0] a, logic [31:0] b, logic [2:0] op);
    logic [32:0] s;
    logic [31:0] r;
    logic c, v;
    s = {1'b0, a} + {1'b0, (op == 3'd1) ? ~b : b} + {32'd0, op == 3'd1};
    c = 1'b0;
    v = 1'b0;
    case (op)
      3'd0: begin r = s[31:0]; c = s[32]; v = (a[31] == b[31]) && (r[31] != a[31]); end
      3'd1: begin r = s[31:0]; c = s[32]; v = (a[31] != b[31]) && (r[31] != a[31]); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = (b == 0) ? a : a % b;
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: r = {31'd0, $signed(a) < $signed(b)};
      default: r = a ^ b;
    endcase
    return {c, r == 32'd0, r[31], v, r};
  endfunction

  assign {u0_fl, u0_res} = alu_fn(u0_alu_a, u0_alu_b, u0_alu_ctrl);
  assign {u3_fl, u3_res} = alu_fn(u3_alu_a, u3_alu_b, u3_alu_ctrl);

  alu_arbiter #(.N(N), .NREQ(NREQ), .IDW(IDW), .EXEC_CYCLES(1)) u0 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(u0_req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .alu_a(u0_alu_a), .alu_b(u0_alu_b), .alu_ctrl(u0_alu_ctrl),
    .alu_result(u0_res), .alu_flags(u0_fl),
    .rsp_valid(u0_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(u0_rsp_id),
    .rsp_result(u0_rsp_result), .rsp_flags(u0_rsp_flags));

  alu_arbiter #(.N(N), .NREQ(NREQ), .IDW(IDW), .EXEC_CYCLES(3)) u3 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(u3_req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .alu_a(u3_alu_a), .alu_b(u3_alu_b), .alu_ctrl(u3_alu_ctrl),
    .alu_result(u3_res), .alu_flags(u3_fl),
    .rsp_valid(u3_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(u3_rsp_id),
    .rsp_result(u3_rsp_result), .rsp_flags(u3_rsp_flags));

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '1;
    rsp_ready = 1'b0;
    @(negedge clk);
    chk("rst_ready", u0_req_ready, 0);
    tick();
    tick();
    rst = 1'b0;
    req_valid = '0;
    chk("rst_valid", u0_rsp_valid, 0);
    chk("rst_rsp", {u0_rsp_id, u0_rsp_flags, u0_rsp_result}, 0);
    chk("rst_alu", {u0_alu_ctrl, u0_alu_a, u0_alu_b}, 0);
  endtask

  task automatic set_req(int id, logic [31:0] a, logic [31:0] b, logic [2:0] op);
    req_a[id*N +: N] = a;
    req_b[id*N +: N] = b;
    req_op[id*3 +: 3] = op;
  endtask

  // waits (bounded) at negedges for a u0 grant and returns its index, -1 on timeout
  task automatic wait_grant(output int g);
    int n;
    n = 0;
    g = -1;
    @(negedge clk);
    while (u0_req_ready == 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    for (int j = 0; j < NREQ; j++) if (u0_req_ready[j]) g = j;
    chk("grant_seen", u0_req_ready != 0, 1);
  endtask

  typedef struct {
    int id;
    logic [31:0] a, b;
    logic [2:0] op;
    logic [31:0] res;
    logic [3:0] fl;
  } vec_t;

  initial begin
    vec_t tv[9];
    int g, lat, exp_c[3];
    tv[0] = '{0, 32'd5, 32'd3, 3'd0, 32'd8, 4'b0000};
    tv[1] = '{1, 32'd7, 32'd7, 3'd1, 32'd0, 4'b1100};
    tv[2] = '{2, 32'h7FFF_FFFF, 32'd1, 3'd0, 32'h8000_0000, 4'b0011};
    tv[3] = '{3, 32'hFFFF_FFFF, 32'd1, 3'd0, 32'd0, 4'b1100};
    tv[4] = '{0, 32'd3, 32'd5, 3'd1, 32'hFFFF_FFFE, 4'b0010};
    tv[5] = '{1, 32'hF0, 32'h3C, 3'd2, 32'h30, 4'b0000};
    tv[6] = '{2, 32'd20, 32'd6, 3'd4, 32'd2, 4'b0000};
    tv[7] = '{3, 32'd9, 32'd0, 3'd5, 32'hFFFF_FFFF, 4'b0010};
    tv[8] = '{0, 32'h8000_0000, 32'd1, 3'd1, 32'h7FFF_FFFF, 4'b1001};
    do_reset();
    for (int i = 0; i < 9; i++) begin
      req_valid = '0;
      req_valid[tv[i].id] = 1'b1;
      set_req(tv[i].id, tv[i].a, tv[i].b, tv[i].op);
      rsp_ready = 1'b1;
      wait_grant(g);
      chk("tv_grant", g, tv[i].id);
      tick();
      req_valid = '0;
      lat = 1;
      while (!u0_rsp_valid && lat < 20) begin tick(); lat++; end
      chk("tv_latency", lat, 2);
      chk("tv_id", u0_rsp_id, tv[i].id);
      chk("tv_result", u0_rsp_result, tv[i].res);
      chk("tv_flags", u0_rsp_flags, tv[i].fl);
      tick();
      chk("tv_drop", u0_rsp_valid, 0);
    end
    // contention between requesters 0 and 2, both held valid
    exp_c = FP ? '{0, 0, 0} : '{0, 2, 0};
    do_reset();
    set_req(0, 32'd1, 32'd2, 3'd0);
    set_req(2, 32'd4, 32'd1, 3'd1);
    req_valid = 4'b0101;
    rsp_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_grant(g);
      chk("cont_grant", g, exp_c[k]);
      tick();
    end
    // backpressure: response held for five cycles with rsp_ready low
    do_reset();
    set_req(1, 32'd7, 32'd7, 3'd1);
    req_valid = 4'b0010;
    wait_grant(g);
    tick();
    req_valid = 4'b1111;
    lat = 1;
    while (!u0_rsp_valid && lat < 20) begin tick(); lat++; end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_valid", u0_rsp_valid, 1);
      chk("bp_data", {u0_rsp_id, u0_rsp_flags, u0_rsp_result}, {2'd1, 4'b1100, 32'd0});
      chk("bp_ready", u0_req_ready, 0);
      tick();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_accept_valid", u0_rsp_valid, 1);
    tick();
    chk("bp_after", u0_rsp_valid, 0);
    @(negedge clk);
    chk("bp_regrant", u0_req_ready != 0, 1);
    // multicycle instance: EXEC_CYCLES=3
    do_reset();
    set_req(3, 32'd20, 32'd6, 3'd4);
    req_valid = 4'b1000;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("mc_grant", u3_req_ready, 4'b1000);
    tick();
    req_valid = '0;
    lat = 1;
    while (!u3_rsp_valid && lat < 20) begin tick(); lat++; end
    chk("mc_latency", lat, 4);
    chk("mc_result", u3_rsp_result, 2);
    chk("mc_id", u3_rsp_id, 3);
    // reset in the middle of EXEC discards the operation
    do_reset();
    set_req(2, 32'd1, 32'd1, 3'd0);
    req_valid = 4'b0100;
    rsp_ready = 1'b1;
    wait_grant(g);
    tick();
    req_valid = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("mid_rst_quiet", {u0_rsp_valid, u3_rsp_valid}, 0);
      tick();
    end
    req_valid = 4'b1010;
    @(negedge clk);
    chk("mid_rst_ptr", u0_req_ready, 4'b0010);
    tick();
    // randomized traffic against a transaction-level model
    do_reset();
    begin
      bit busy;
      int ptr, due, eid;
      logic [35:0] eres;
      busy = 1'b0;
      ptr = 0;
      due = 0;
      eid = 0;
      eres = '0;
      for (int i = 0; i < 400; i++) begin
        req_valid = NREQ'($urandom);
        rsp_ready = ($urandom % 3) != 0;
        for (int j = 0; j < NREQ; j++)
          set_req(j, $urandom, ($urandom % 4 == 0) ? 32'($urandom_range(0, 7)) : $urandom, 3'($urandom));
        @(negedge clk);
        if (!busy) begin
          g = -1;
          for (int k = NREQ - 1; k >= 0; k--)
            if (req_valid[(ptr + k) % NREQ]) g = (ptr + k) % NREQ;
          chk("rnd_ready", u0_req_ready, g < 0 ? 0 : (1 << g));
          chk("rnd_idle_valid", u0_rsp_valid, 0);
          if (g >= 0) begin
            busy = 1'b1;
            due = i + 2;
            eid = g;
            eres = alu_fn(req_a[g*N +: N], req_b[g*N +: N], req_op[g*3 +: 3]);
            ptr = FP ? 0 : (g + 1) % NREQ;
          end
        end else begin
          chk("rnd_busy_ready", u0_req_ready, 0);
          chk("rnd_valid", u0_rsp_valid, i >= due);
          if (i >= due) begin
            chk("rnd_rsp", {u0_rsp_id, u0_rsp_flags, u0_rsp_result}, {IDW'(eid), eres});
            if (rsp_ready) busy = 1'b0;
          end
        end
        tick();
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
